// File: rtl/piso_pkg.sv
// piso_pkg: shared state type and default word width for the PISO transmitter
package piso_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} tx_state_t;
  localparam int DEFAULT_WIDTH = 16;
endpackage

// File: rtl/piso_shreg.sv
// piso_shreg: loadable zero-fill shift register with selectable direction and serial tap
module piso_shreg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             sh,
  input  logic             dir,
  input  logic [WIDTH-1:0] din,
  output logic             so
);
  logic [WIDTH-1:0] shreg_q, shreg_d;
  always_comb shreg_d = ld ? din : !sh ? shreg_q :
                        dir ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
  always_ff @(posedge clk) shreg_q <= rst ? '0 : shreg_d;
  assign so = dir ? shreg_q[WIDTH-1] : shreg_q[0];
endmodule

// File: rtl/piso_tx.sv
// piso_tx: valid/ready word capture, serialised one bit per shift_en with framing strobe
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sframe,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  tx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ld, sh, last, so;
  always_comb begin
    ld      = state_q == IDLE && din_valid;
    sh      = state_q == SHIFT && shift_en;
    last    = cnt_q == CW'(WIDTH - 1);
    state_d = ld ? SHIFT : state_q == DONE ? IDLE : sh && last ? DONE : state_q;
    cnt_d   = ld ? '0 : sh && !last ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
    cnt_q   <= rst ? '0 : cnt_d;
  end
  piso_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk(clk), .rst(rst), .ld(ld), .sh(sh), .dir(MSB_FIRST), .din(din), .so(so)
  );
  assign din_ready = state_q == IDLE && !rst;
  assign sframe    = state_q == SHIFT;
  assign sout      = sframe && so;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: MSB- and LSB-first transmitters on shared stimulus against a frame-level model
module tb_piso_tx;
  import piso_pkg::*;
  localparam int W = DEFAULT_WIDTH;
  logic clk = 0, rst = 1, din_valid = 0, shift_en = 0;
  logic [W-1:0] din = '0;
  logic dr_m, sf_m, by_m, dn_m, so_m, dr_l, sf_l, by_l, dn_l, so_l;
  int checks = 0, failures = 0;
  int m_pos = -1;
  logic [W-1:0] m_word = '0, rx_m = '0, rx_l = '0;
  int rx_n = 0, cy = 0, t_x = 0, t_d = 0, t_r = 0, t_sr = 0, nsf = 0, ndone = 0;
  logic pr_ready = 0, pr_sf = 0;
  always #5 clk = ~clk;
  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(dr_m),
    .shift_en(shift_en), .sout(so_m), .sframe(sf_m), .busy(by_m), .done(dn_m)
  );
  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(dr_l),
    .shift_en(shift_en), .sout(so_l), .sframe(sf_l), .busy(by_l), .done(dn_l)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cy);
    end
  endtask
  task automatic cyc(input logic r, input logic v, input logic [W-1:0] d, input logic se);
    logic esf;
    int i;
    rst = r; din_valid = v; din = d; shift_en = se;
    if (sf_m && se) begin
      rx_m = {rx_m[W-2:0], so_m};
      rx_l = {so_l, rx_l[W-1:1]};
      rx_n++;
    end
    @(posedge clk);
    cy++;
    if (r) begin m_pos = -1; rx_n = 0; end
    else if (m_pos == -1) begin
      if (v) begin m_word = d; m_pos = 0; rx_n = 0; t_x = cy; nsf = 0; ndone = 0; end
    end
    else if (m_pos == W) m_pos = -1;
    else if (se) m_pos++;
    @(negedge clk);
    esf = m_pos >= 0 && m_pos < W;
    i = esf ? m_pos : 0;
    chk("din_ready", dr_m, m_pos == -1 && !r);
    chk("sframe", sf_m, esf);
    chk("busy", by_m, m_pos != -1);
    chk("done", dn_m, m_pos == W);
    chk("sout_msb", so_m, esf ? m_word[W-1-i] : 1'b0);
    chk("sout_lsb", so_l, esf ? m_word[i] : 1'b0);
    chk("ctl_lsb", {dr_l, sf_l, by_l, dn_l}, {m_pos == -1 && !r, esf, m_pos != -1, m_pos == W});
    if (sf_m) nsf++;
    if (sf_m && !pr_sf) t_sr = cy;
    if (dn_m) begin ndone++; t_d = cy; end
    if (dr_m && !pr_ready) t_r = cy;
    pr_ready = dr_m; pr_sf = sf_m;
    if (m_pos == W) begin
      chk("rx_msb", rx_m, m_word);
      chk("rx_lsb", rx_l, m_word);
      chk("rx_bits", rx_n, W);
    end
  endtask
  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, 1);
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && m_pos != -1; i++) cyc(0, 0, '0, 1);
    chk("drain_idle", dr_m, 1'b1);
  endtask
  initial begin
    int t1;
    cyc(1, 0, '0, 1);
    cyc(1, 0, '0, 1);
    chk("rst_outs", {dr_m, sf_m, by_m, dn_m, so_m}, 5'b0);
    cyc(0, 0, '0, 1);
    chk("rst_release_ready", dr_m, 1'b1);
    cyc(0, 1, 16'hA5C3, 1);
    drain();
    chk("a5c3_done_lat", t_d - t_x, W);
    chk("a5c3_ready_lat", t_r - t_x, W + 1);
    chk("a5c3_done_once", ndone, 1);
    chk("a5c3_sframe_cnt", nsf, W);
    cyc(0, 1, 16'h0001, 1);
    drain();
    chk("0001_done_lat", t_d - t_x, W);
    cyc(0, 1, 16'hFF00, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, 0);
    drain();
    chk("stall_sframe_cnt", nsf, W + 3);
    chk("stall_done_once", ndone, 1);
    cyc(0, 1, 16'hA5C3, 1);
    t1 = t_sr;
    for (int i = 0; i < 40 && t_sr == t1; i++) cyc(0, 1, 16'h1234, 1);
    chk("b2b_period", t_sr - t1, W + 2);
    chk("b2b_word", m_word, 16'h1234);
    drain();
    cyc(0, 1, 16'hBEEF, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, '0, 1);
    cyc(1, 0, '0, 1);
    chk("abort_sframe", sf_m, 1'b0);
    chk("abort_busy", by_m, 1'b0);
    idle_n(3);
    chk("abort_no_done", ndone, 0);
    cyc(0, 1, 16'h0F0F, 1);
    drain();
    chk("0f0f_done_once", ndone, 1);
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(99) == 0, 1'($urandom_range(1)), W'($urandom), $urandom_range(3) != 0);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
